// File: rtl/rle_if.sv
// Lane-side byte stream and element-memory write port of one RLE decompressor.
interface rle_if #(
    parameter int unsigned ADDR_W = 8
);
    logic              start;
    logic [7:0]        in_byte;
    logic              in_valid;
    logic              in_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;
    logic              eob;
    logic [ADDR_W:0]   elem_count;
    logic              busy;
    logic              overflow;

    modport master (
        output start, in_byte, in_valid,
        input  in_ready, wr_en, wr_addr, wr_data, eob, elem_count, busy, overflow
    );

    modport slave (
        input  start, in_byte, in_valid,
        output in_ready, wr_en, wr_addr, wr_data, eob, elem_count, busy, overflow
    );
endinterface

// File: rtl/rle_decompressor.sv
// Per-lane run-length decoder: expands header/literal/zero-run tokens into
// 32-bit element writes and pulses eob on the end-of-object marker.
module rle_decompressor #(
    parameter int unsigned ADDR_W = 8
) (
    input logic   clk,
    input logic   reset,
    rle_if.slave  bus
);
    localparam int unsigned CNT_W = ADDR_W + 1;

    typedef enum logic [1:0] {IDLE, HEADER, LITERAL, ZERO_RUN} state_t;

    state_t            state_q, state_d;
    logic [7:0]        left_q, left_d;
    logic [1:0]        idx_q, idx_d;
    logic [23:0]       asm_q, asm_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              ovf_q, ovf_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [31:0]       wr_data_q, wr_data_d;
    logic              eob_q, eob_d;
    logic              in_ready_q, in_ready_d;
    logic              busy_q, busy_d;

    logic              accept;
    logic              emit;
    logic [31:0]       emit_data;

    assign accept = bus.in_valid & in_ready_q;

    // Next-state, element emission and output decode
    always_comb begin
        state_d   = state_q;
        left_d    = left_q;
        idx_d     = idx_q;
        asm_d     = asm_q;
        count_d   = count_q;
        ovf_d     = ovf_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        eob_d     = 1'b0;
        emit      = 1'b0;
        emit_data = '0;

        case (state_q)
            IDLE: begin
            end
            HEADER: begin
                if (accept) begin
                    if (bus.in_byte == 8'h80) begin
                        state_d = IDLE;
                        eob_d   = 1'b1;
                    end else if (bus.in_byte[7]) begin
                        left_d  = 8'(bus.in_byte[6:0]);
                        state_d = ZERO_RUN;
                    end else begin
                        left_d  = 8'(bus.in_byte[6:0]) + 8'd1;
                        idx_d   = 2'd0;
                        state_d = LITERAL;
                    end
                end
            end
            LITERAL: begin
                if (accept) begin
                    // First byte lands in the low byte; the fourth completes the element
                    if (idx_q == 2'd3) begin
                        emit      = 1'b1;
                        emit_data = {bus.in_byte, asm_q};
                        left_d    = left_q - 8'd1;
                        if (left_q == 8'd1) begin
                            state_d = HEADER;
                        end
                    end else begin
                        asm_d = {bus.in_byte, asm_q[23:8]};
                    end
                    idx_d = idx_q + 2'd1;
                end
            end
            ZERO_RUN: begin
                emit   = 1'b1;
                left_d = left_q - 8'd1;
                if (left_q == 8'd1) begin
                    state_d = HEADER;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // The count doubles as the write address; its top bit marks a full memory
        if (emit) begin
            if (!count_q[ADDR_W]) begin
                wr_en_d   = 1'b1;
                wr_addr_d = count_q[ADDR_W-1:0];
                wr_data_d = emit_data;
                count_d   = count_q + CNT_W'(1);
            end else begin
                ovf_d = 1'b1;
            end
        end

        // A start pulse always wins, dropping any byte or write on the same edge
        if (bus.start) begin
            state_d   = HEADER;
            left_d    = 8'd0;
            idx_d     = 2'd0;
            count_d   = '0;
            ovf_d     = 1'b0;
            wr_en_d   = 1'b0;
            wr_addr_d = '0;
            eob_d     = 1'b0;
        end

        in_ready_d = (state_d == HEADER) || (state_d == LITERAL);
        busy_d     = (state_d != IDLE);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            left_q     <= 8'd0;
            idx_q      <= 2'd0;
            asm_q      <= 24'd0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= 32'd0;
            eob_q      <= 1'b0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            left_q     <= left_d;
            idx_q      <= idx_d;
            asm_q      <= asm_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            eob_q      <= eob_d;
            in_ready_q <= in_ready_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.wr_en      = wr_en_q;
    assign bus.wr_addr    = wr_addr_q;
    assign bus.wr_data    = wr_data_q;
    assign bus.eob        = eob_q;
    assign bus.elem_count = count_q;
    assign bus.busy       = busy_q;
    assign bus.overflow   = ovf_q;
endmodule

// File: tb/tb_rle_decompressor.sv
// Scoreboard bench: directed RLE streams into an 8-bit-address lane and a
// 2-bit-address lane; a monitor pops expected writes/eob counts as they appear.
module tb_rle_decompressor;
    typedef struct packed {
        logic [7:0]  addr;
        logic [31:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    int   lowrdy = 0;

    wr_t        qw[$];
    wr_t        qw2[$];
    logic [8:0] qe[$];
    logic [8:0] qe2[$];

    rle_if #(.ADDR_W(8)) bus8 ();
    rle_if #(.ADDR_W(2)) bus2 ();

    rle_decompressor #(.ADDR_W(8)) dut8 (.clk(clk), .reset(reset), .bus(bus8));
    rle_decompressor #(.ADDR_W(2)) dut2 (.clk(clk), .reset(reset), .bus(bus2));

    always #5 clk = ~clk;

    // Monitor: every write / eob the DUTs present must match the head of its queue
    always @(negedge clk) begin
        wr_t        e;
        logic [8:0] c;
        if (bus8.busy && !bus8.in_ready) lowrdy++;
        if (bus8.wr_en) begin
            checks++;
            if (qw.size() == 0) begin
                errors++;
                $display("FAIL wr8 unexpected write addr %0h data %h", bus8.wr_addr, bus8.wr_data);
            end else begin
                e = qw.pop_front();
                if (bus8.wr_addr !== e.addr || bus8.wr_data !== e.data) begin
                    errors++;
                    $display("FAIL wr8 got addr %0h data %h exp addr %0h data %h",
                             bus8.wr_addr, bus8.wr_data, e.addr, e.data);
                end
            end
        end
        if (bus8.eob) begin
            checks++;
            if (qe.size() == 0) begin
                errors++;
                $display("FAIL eob8 unexpected eob count %0d", bus8.elem_count);
            end else begin
                c = qe.pop_front();
                if (bus8.elem_count !== c) begin
                    errors++;
                    $display("FAIL eob8 count got %0d exp %0d", bus8.elem_count, c);
                end
            end
        end
        if (bus2.wr_en) begin
            checks++;
            if (qw2.size() == 0) begin
                errors++;
                $display("FAIL wr2 unexpected write addr %0h data %h", bus2.wr_addr, bus2.wr_data);
            end else begin
                e = qw2.pop_front();
                if (8'(bus2.wr_addr) !== e.addr || bus2.wr_data !== e.data) begin
                    errors++;
                    $display("FAIL wr2 got addr %0h data %h exp addr %0h data %h",
                             bus2.wr_addr, bus2.wr_data, e.addr, e.data);
                end
            end
        end
        if (bus2.eob) begin
            checks++;
            if (qe2.size() == 0) begin
                errors++;
                $display("FAIL eob2 unexpected eob count %0d", bus2.elem_count);
            end else begin
                c = qe2.pop_front();
                if (9'(bus2.elem_count) !== c) begin
                    errors++;
                    $display("FAIL eob2 count got %0d exp %0d", bus2.elem_count, c);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", name, act, exp);
        end
    endtask

    task automatic pulse_start(input bit s2);
        if (s2) bus2.start = 1'b1; else bus8.start = 1'b1;
        @(negedge clk);
        bus2.start = 1'b0;
        bus8.start = 1'b0;
    endtask

    // Called and returns at a falling edge; holds the byte until it is accepted
    task automatic send(input logic [7:0] b, input bit s2);
        int t = 0;
        if (s2) begin bus2.in_byte = b; bus2.in_valid = 1'b1; end
        else    begin bus8.in_byte = b; bus8.in_valid = 1'b1; end
        while (!(s2 ? bus2.in_ready : bus8.in_ready) && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (t >= 300) begin
            checks++;
            errors++;
            $display("FAIL send_timeout byte %h never accepted", b);
        end
        @(negedge clk);
    endtask

    task automatic send_seq(input logic [7:0] s[$], input int gap_mod, input bit s2);
        foreach (s[i]) begin
            send(s[i], s2);
            if (gap_mod > 0 && (i % gap_mod) != 0) begin
                bus8.in_valid = 1'b0;
                bus2.in_valid = 1'b0;
                repeat (i % gap_mod) @(negedge clk);
            end
        end
        bus8.in_valid = 1'b0;
        bus2.in_valid = 1'b0;
    endtask

    task automatic push_wr(input logic [7:0] a, input logic [31:0] d, input bit s2);
        wr_t e;
        e.addr = a;
        e.data = d;
        if (s2) qw2.push_back(e); else qw.push_back(e);
    endtask

    task automatic wait_done();
        int t = 0;
        while ((qw.size() + qw2.size() + qe.size() + qe2.size()) != 0 && t < 300) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (t >= 300) begin
            errors++;
            $display("FAIL drain pending %0d got outstanding exp 0",
                     qw.size() + qw2.size() + qe.size() + qe2.size());
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic push_mixed();
        push_wr(8'd0, 32'h0, 1'b0);
        push_wr(8'd1, 32'h0, 1'b0);
        push_wr(8'd2, 32'h0, 1'b0);
        push_wr(8'd3, 32'hDEADBEEF, 1'b0);
        push_wr(8'd4, 32'h0, 1'b0);
        qe.push_back(9'd5);
    endtask

    initial begin
        logic [7:0] s_lit[$]   = '{8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'h80};
        logic [7:0] s_mix[$]   = '{8'h83, 8'h01, 8'hEF, 8'hBE, 8'hAD, 8'hDE,
                                   8'h00, 8'h00, 8'h00, 8'h00, 8'h80};
        logic [7:0] s_ovf[$]   = '{8'h86, 8'h80};
        logic [7:0] s_abort[$] = '{8'h00, 8'h11, 8'h22};
        logic [7:0] s_end[$]   = '{8'h80};
        int n;
        int t;

        reset = 1'b1;
        bus8.start = 1'b0; bus8.in_valid = 1'b0; bus8.in_byte = 8'h00;
        bus2.start = 1'b0; bus2.in_valid = 1'b0; bus2.in_byte = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 32'(bus8.in_ready), 32'd0);
        chk("rst_busy", 32'(bus8.busy), 32'd0);
        chk("rst_overflow", 32'(bus8.overflow), 32'd0);
        chk("rst_count", 32'(bus8.elem_count), 32'd0);
        chk("rst_wr_addr", 32'(bus8.wr_addr), 32'd0);
        chk("rst_wr_data", bus8.wr_data, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Single literal element
        push_wr(8'd0, 32'h12345678, 1'b0);
        qe.push_back(9'd1);
        pulse_start(1'b0);
        chk("busy_after_start", 32'(bus8.busy), 32'd1);
        send_seq(s_lit, 0, 1'b0);
        wait_done();
        chk("lit_count_hold", 32'(bus8.elem_count), 32'd1);
        chk("lit_busy_done", 32'(bus8.busy), 32'd0);
        chk("lit_overflow", 32'(bus8.overflow), 32'd0);

        // Zero run mixed with literals, back to back
        push_mixed();
        lowrdy = 0;
        pulse_start(1'b0);
        send_seq(s_mix, 0, 1'b0);
        wait_done();
        chk("mix_ready_low", 32'(lowrdy), 32'd3);

        // Same stream with in_valid gaps
        push_mixed();
        lowrdy = 0;
        pulse_start(1'b0);
        send_seq(s_mix, 3, 1'b0);
        wait_done();
        chk("gap_ready_low", 32'(lowrdy), 32'd3);
        chk("gap_count_hold", 32'(bus8.elem_count), 32'd5);

        // Overflow on the 4-entry lane
        for (int i = 0; i < 4; i++) push_wr(8'(i), 32'h0, 1'b1);
        qe2.push_back(9'd4);
        pulse_start(1'b1);
        send_seq(s_ovf, 0, 1'b1);
        wait_done();
        chk("ovf_flag", 32'(bus2.overflow), 32'd1);
        chk("ovf_count", 32'(bus2.elem_count), 32'd4);

        // Abort mid-literal, then an empty object
        pulse_start(1'b0);
        send_seq(s_abort, 0, 1'b0);
        repeat (2) @(negedge clk);
        qe.push_back(9'd0);
        pulse_start(1'b0);
        chk("abort_count_clear", 32'(bus8.elem_count), 32'd0);
        send_seq(s_end, 0, 1'b0);
        wait_done();

        // Reset during a long zero run after ten writes
        for (int i = 0; i < 10; i++) push_wr(8'(i), 32'h0, 1'b0);
        pulse_start(1'b0);
        send(8'hFF, 1'b0);
        bus8.in_valid = 1'b0;
        n = 0;
        t = 0;
        while (n < 10 && t < 100) begin
            @(negedge clk);
            t++;
            if (bus8.wr_en) n++;
        end
        chk("zr_writes_before_reset", 32'(n), 32'd10);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("zr_rst_wr_en", 32'(bus8.wr_en), 32'd0);
        chk("zr_rst_eob", 32'(bus8.eob), 32'd0);
        chk("zr_rst_busy", 32'(bus8.busy), 32'd0);
        chk("zr_rst_in_ready", 32'(bus8.in_ready), 32'd0);
        chk("zr_rst_count", 32'(bus8.elem_count), 32'd0);
        chk("zr_rst_addr", 32'(bus8.wr_addr), 32'd0);
        chk("zr_rst_data", bus8.wr_data, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        chk("zr_idle_after_reset", 32'(bus8.busy), 32'd0);

        // Normal decode after reset
        push_wr(8'd0, 32'h12345678, 1'b0);
        qe.push_back(9'd1);
        pulse_start(1'b0);
        send_seq(s_lit, 0, 1'b0);
        wait_done();
        chk("post_reset_count", 32'(bus8.elem_count), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/rle_decompressor.md
# rle_decompressor

Per-lane decompressor for the ODE accelerator I/O path. It sits directly downstream of the I/O controller, which slices each incoming 32-bit bus word into four byte lanes (A, B, U, rest). One instance per lane consumes a run-length-encoded byte stream, expands it into 32-bit matrix elements written to the lane's element memory, and pulses `eob` when the object's end marker is decoded. The I/O controller uses `eob` to mark that lane finished.

## Interface
- `ADDR_W`, 8: element memory address width; capacity is 2^ADDR_W elements.
- `clk` input 1: single clock, all state updates on rising edge.
- `reset` input 1: synchronous, active-high; sampled on rising edge of `clk`.
- `start` input 1: one-cycle pulse that begins a new object (or aborts the current one).
- `in_byte` input 8: compressed byte from the I/O controller lane.
- `in_valid` input 1: `in_byte` is valid this cycle.
- `in_ready` output 1: block accepts `in_byte` this cycle; a byte transfers on an edge where `in_valid & in_ready`.
- `wr_en` output 1: element write strobe.
- `wr_addr` output ADDR_W: element address.
- `wr_data` output 32: element value.
- `eob` output 1: one-cycle pulse when the end-of-object marker has been consumed.
- `elem_count` output ADDR_W+1: number of elements written for the current object; valid during `eob` and held until the next `start`.
- `busy` output 1: state is not IDLE.
- `overflow` output 1: sticky; the object exceeded 2^ADDR_W elements.

## Operation
- Token format (header byte `h`):
  - `h == 8'h80`: end of object.
  - `h` in `8'h81..8'hFF`: zero run of `h[6:0]` elements (1..127).
  - `h` in `8'h00..8'h7F`: literal block of `h[6:0]+1` elements (1..128). Each element is 4 following bytes, little-endian (first byte goes to `[7:0]`).
- FSM states: IDLE, HEADER, LITERAL, ZERO_RUN.
  - IDLE: `in_ready` is 0. On `start`, go to HEADER and clear the address, `elem_count`, and `overflow`.
  - HEADER: `in_ready` is 1. The accepted header selects the next state: LITERAL, ZERO_RUN, or IDLE with an `eob` pulse.
  - LITERAL: `in_ready` is 1. Bytes shift into the assembly register using a 2-bit byte index. On acceptance of byte index 3, write the element and decrement the elements-left counter. After the last element, return to HEADER.
  - ZERO_RUN: `in_ready` is 0. Write one zero element per cycle and decrement the run counter. After the last write, return to HEADER.
- Address rules:
  - Each write increments the address; `elem_count` increments alongside.
  - A write that would target an address beyond 2^ADDR_W-1 is suppressed (`wr_en` stays 0) and sets `overflow`.
  - After overflow, bytes are still consumed and decoded until the end marker, so the stream stays aligned.
  - `elem_count` saturates at 2^ADDR_W.
- `start` in any non-IDLE state aborts the object: go to HEADER, clear counters, no `eob` is issued, and all partial literal bytes are discarded.
- If `start` and an accepted byte fall on the same edge, `start` wins and the byte is dropped.
- Reset values: state IDLE; `in_ready`, `wr_en`, `eob`, `busy`, `overflow` all 0; `wr_addr`, `wr_data`, `elem_count` all 0.

## Timing
- `wr_en`, `wr_addr`, `wr_data`, and `eob` are registered.
- Literal latency: if the 4th byte is accepted at edge m, `wr_en` is high in the cycle following edge m.
- Zero-run timing for header `8'h80+N` accepted at edge k:
  - `in_ready` is low for N cycles.
  - `wr_en` is high in the N cycles following edges k+1..k+N.
  - State returns to HEADER at edge k+N, so a new header can be accepted at edge k+N+1.
- End marker: if `8'h80` is accepted at edge e, `eob` is high for exactly the cycle after e, and `busy` falls in that same cycle.
- Throughput:
  - Literal: 1 byte per cycle with no bubbles, including across element and header boundaries.
  - Zero run: 1 element per cycle.
- Gaps in `in_valid` stall the FSM without losing state.
- Synchronous reset mid-operation reaches all reset values on the next edge, with no `eob` pulse.

## Test plan
- Literal block:
  - Stimulus: after `start`, send `00 78 56 34 12 80`.
  - Required: one write, addr 0, data `32'h12345678`; then `eob` with `elem_count` = 1.
- Zero run mixed with literal:
  - Stimulus: send `83 01 EF BE AD DE 00 00 00 00 80`.
  - Required: zeros at addrs 0–2, then `32'hDEADBEEF` at 3 and 0 at 4.
  - Required: `in_ready` low exactly 3 cycles; `eob` with `elem_count` = 5.
- Random `in_valid` gaps over the previous stream:
  - Required: identical write sequence and data; no write while an element is partially assembled.
- Overflow with `ADDR_W` = 2:
  - Stimulus: send `86 80`.
  - Required: writes to addrs 0–3 only; `overflow` = 1; `eob` still pulses; `elem_count` = 4.
- Abort:
  - Stimulus: send `00 11 22`, then pulse `start`, then send `80`.
  - Required: no write and no `eob` before the abort; `eob` with `elem_count` = 0 after `80`.
- Reset during a zero run:
  - Stimulus: header `FF`; assert `reset` after 10 writes.
  - Required: next cycle all outputs are at reset values; no further writes; a subsequent `start` decodes normally.
